// File: rtl/timer_down_modn.sv
// timer_down_modn: programmable down-counting interval timer with one-shot/periodic terminal tick
// Ports: i_clk clock, i_rst_n async active-low reset, i_en count enable,
//   i_start/i_stop start (latches i_period, i_mode) and abort requests,
//   o_count remaining count, o_tick one-cycle terminal pulse,
//   o_busy high in RUN, o_done high after a one-shot completes.
module timer_down_modn #(
  parameter int WIDTH = 16
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_en,
  input  logic             i_start,
  input  logic             i_stop,
  input  logic             i_mode,
  input  logic [WIDTH-1:0] i_period,
  output logic [WIDTH-1:0] o_count,
  output logic             o_tick,
  output logic             o_busy,
  output logic             o_done
);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t           r_state;
  logic [WIDTH-1:0] r_count;
  logic [WIDTH-1:0] r_period;
  logic             r_mode;
  logic             r_tick;
  logic             r_busy;
  logic             r_done;
  logic             w_go;
  assign w_go = i_start && (i_period != '0);
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state  <= IDLE;
      r_count  <= '0;
      r_period <= '0;
      r_mode   <= 1'b0;
      r_tick   <= 1'b0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      r_tick <= 1'b0;
      if (i_stop) begin
        r_state <= IDLE;
        r_count <= '0;
        r_busy  <= 1'b0;
        r_done  <= 1'b0;
      end else if (w_go) begin
        r_state  <= RUN;
        r_period <= i_period;
        r_mode   <= i_mode;
        r_count  <= i_period - WIDTH'(1);
        r_busy   <= 1'b1;
        r_done   <= 1'b0;
      end else if (r_state == RUN && i_en) begin
        if (r_count != '0) begin
          r_count <= r_count - WIDTH'(1);
        end else begin
          // terminal count: reload from the latched period or retire to DONE
          r_tick <= 1'b1;
          if (r_mode) begin
            r_count <= r_period - WIDTH'(1);
          end else begin
            r_state <= DONE;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
          end
        end
      end
    end
  end
  assign o_count = r_count;
  assign o_tick  = r_tick;
  assign o_busy  = r_busy;
  assign o_done  = r_done;
endmodule

// File: doc/timer_down_modn.md
Name: timer_down_modn

Overview:
Programmable down-counting interval timer. It is the count-down and terminal-event counterpart of the team's free-running mod-N up-counter. The block loads a period, decrements under a clock enable and emits a one-cycle tick at terminal count. It supports one-shot and periodic (auto-reload) modes and has a start/stop/done handshake. It schedules sensor excitation windows and decimator dump strobes in the iCESDM readout chain.

Parameters:
WIDTH, 16, width of the period and count registers.

Ports:
i_clk  input  1  system clock; all state changes on rising edge.
i_rst_n  input  1  asynchronous active-low reset.
i_en  input  1  count enable; decrement only when high.
i_start  input  1  start/restart request, sampled on the clock edge.
i_stop  input  1  abort request, sampled on the clock edge.
i_mode  input  1  0 = one-shot, 1 = periodic; latched at start.
i_period  input  WIDTH  period P in enabled cycles; latched at start.
o_count  output  WIDTH  current remaining count.
o_tick  output  1  registered one-cycle terminal-count pulse.
o_busy  output  1  high while in RUN.
o_done  output  1  high while in DONE (one-shot completed).

Behaviour:
- States: IDLE, RUN, DONE. o_busy = (state==RUN); o_done = (state==DONE).
- Reset (i_rst_n low, asynchronous, any time including mid-run):
  - state IDLE; o_count = 0; o_tick = 0; o_busy = 0; o_done = 0.
  - Latched period and mode cleared to 0.
- Priority per edge: reset > i_stop > i_start > count/terminal logic.
- i_stop (any state): next state IDLE; o_count = 0; o_tick = 0. Suppresses any tick due on that edge.
- i_start with i_period != 0, from any state (no stop):
  - Latch P = i_period and M = i_mode.
  - o_count <= P-1; state RUN; o_tick = 0 for that edge.
  - A restart during RUN discards the old count with no tick, even if the old count was 0.
  - A start from DONE clears o_done on the same edge.
- i_start with i_period == 0: ignored. State, count and latched values are unchanged, and no tick is produced.
- i_start and i_stop are honoured regardless of i_en.
- RUN, i_en low: o_count held; o_tick = 0.
- RUN, i_en high, o_count != 0: o_count <= o_count-1; o_tick = 0.
- RUN, i_en high, o_count == 0 (terminal):
  - o_tick <= 1 for exactly one cycle.
  - If M=1: o_count <= P-1 and stay in RUN. Uses the latched P; later i_period changes have no effect until the next start.
  - If M=0: o_count stays 0; state DONE.
- Timing with i_en held high, start sampled at edge k:
  - o_count = P-1 after edge k.
  - o_count reaches 0 after edge k+P-1.
  - o_tick is high in the cycle following edge k+P.
  - Periodic mode: subsequent ticks every P cycles.
  - P=1: tick every cycle in periodic mode (o_tick continuously high); count stays 0.
- Gated i_en: ticks occur after P enabled edges, counted from the start edge exclusive.
- DONE: holds o_count=0, o_tick=0 and o_done=1 until start or stop.
- IDLE: o_tick=0; o_count=0.
- Count arithmetic is modulo 2^WIDTH but never underflows, because 0 is the terminal value. P = 2^WIDTH-1 is supported.

Test Plan:
1. Reset, then start with P=5, M=1, i_en=1 → o_count 4,3,2,1,0,4,…; o_tick high on cycles 5, 10 and 15 after the start edge; o_busy=1 throughout.
2. Start with P=3, M=0; i_en toggles 1,0,1,0,1,1 → count decrements only on enabled edges; one tick after the 3rd enabled edge; then o_done=1, o_busy=0, o_count=0 held for 10 cycles.
3. Periodic P=4 running; at count 0 with i_en=1, assert i_start with i_period=7 → no tick on that edge; o_count=6; the next tick comes 7 cycles later.
4. Periodic P=4: assert i_stop and i_start together at the terminal edge → IDLE, o_tick=0, o_count=0. Separately, start with i_period=0 from IDLE → remains IDLE.
5. P=1, M=1, i_en=1 → o_tick continuously high after the first cycle. Separately, P=16'hFFFF → first tick at cycle 65535.
6. Pulse i_rst_n low asynchronously mid-RUN (between edges) → all outputs 0 immediately. After release, the block stays IDLE until a new i_start.
